// File: rtl/restoring_divider.sv
// Sequential restoring divider: {dividend2,dividend1} / divisor over DWIDTH cycles.
// Divide-by-zero and quotient overflow finish in a single cycle with saturated results.
module restoring_divider #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DWIDTH-1:0] dividend1,
  input  logic [DWIDTH-1:0] dividend2,
  input  logic [DWIDTH-1:0] divisor,
  output logic [DWIDTH-1:0] quotient,
  output logic [DWIDTH-1:0] remainder,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic              overflow
);

  localparam int CW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]     count_reg;
  logic [DWIDTH-1:0] r_reg;
  logic [DWIDTH-1:0] q_reg;
  logic [DWIDTH-1:0] divisor_reg;

  logic              accept;
  logic              zero_div;
  logic              too_big;
  logic              last_iter;
  logic [DWIDTH:0]   trial;
  logic              fits;
  logic [DWIDTH-1:0] r_new;
  logic [DWIDTH-1:0] q_new;

  // The partial remainder stays below the divisor after every step, so only
  // the trial value needs the extra bit; the stored remainder is DWIDTH wide.
  always_comb begin
    accept    = start && (state_reg != RUN);
    zero_div  = (divisor == '0);
    too_big   = !zero_div && (dividend2 >= divisor);
    last_iter = (count_reg == CW'(DWIDTH - 1));
    trial     = {r_reg, q_reg[DWIDTH-1]};
    fits      = (trial >= {1'b0, divisor_reg});
    r_new     = fits ? DWIDTH'(trial - {1'b0, divisor_reg}) : trial[DWIDTH-1:0];
    q_new     = DWIDTH'({q_reg, fits});
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) state_next = (zero_div || too_big) ? DONE : RUN;
        else       state_next = IDLE;
      end
      RUN: begin
        if (last_iter) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      r_reg       <= '0;
      q_reg       <= '0;
      divisor_reg <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        div_by_zero <= zero_div;
        overflow    <= too_big;
        count_reg   <= '0;
        if (zero_div || too_big) begin
          quotient  <= '1;
          remainder <= dividend2;
        end else begin
          r_reg       <= dividend2;
          q_reg       <= dividend1;
          divisor_reg <= divisor;
        end
      end else if (state_reg == RUN) begin
        r_reg     <= r_new;
        q_reg     <= q_new;
        count_reg <= count_reg + 1'b1;
        if (last_iter) begin
          quotient  <= q_new;
          remainder <= r_new;
        end
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider: expected results queued at start,
// compared against the DUT outputs whenever done pulses.
module tb_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend1, dividend2, divisor;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, div_by_zero, overflow;

  restoring_divider #(.DWIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend1(dividend1), .dividend2(dividend2), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d2, d1, dv;
    logic [W-1:0] q, r;
    logic         dz, ov;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;
  int done_count = 0;
  int ops_expected = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs === expv) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  function automatic exp_t model(input logic [W-1:0] d2, d1, dv);
    exp_t e;
    logic [2*W-1:0] n;
    e.d2 = d2; e.d1 = d1; e.dv = dv;
    e.dz = (dv == 0);
    e.ov = (dv != 0) && (d2 >= dv);
    if (e.dz || e.ov) begin
      e.q = 8'hFF;
      e.r = d2;
    end else begin
      n   = {d2, d1};
      e.q = W'(n / dv);
      e.r = W'(n % dv);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      done_count++;
      check("busy_with_done", busy, 0);
      check("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        $display("op %02h%02h / %02h -> q=%02h r=%02h dz=%0b ov=%0b", e.d2, e.d1, e.dv,
                 quotient, remainder, div_by_zero, overflow);
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.dz);
        check("overflow", overflow, e.ov);
        if (!e.dz && !e.ov) begin
          check("identity", {e.d2, e.d1}, 32'(quotient) * 32'(e.dv) + 32'(remainder));
          check("rem_lt_div", remainder < e.dv, 1);
        end
      end
    end
  end

  // Drive one request across a clock edge, then scramble the operand inputs.
  task automatic start_op(input logic [W-1:0] d2, d1, dv);
    sb.push_back(model(d2, d1, dv));
    ops_expected++;
    start = 1'b1; dividend2 = d2; dividend1 = d1; divisor = dv;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend1 = W'($urandom); dividend2 = W'($urandom); divisor = W'($urandom);
  endtask

  // Returns at the falling edge inside the done cycle; latency counted in falling edges.
  task automatic wait_done(input int exp_edges, input int exp_busy);
    int  n = 0;
    int  b = 0;
    bit  seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
      else if (busy) b++;
    end
    check("done_seen", seen, 1);
    if (exp_edges > 0) check("done_latency", n, exp_edges);
    if (exp_busy >= 0) check("busy_cycles", b, exp_busy);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    dividend1 = '0; dividend2 = '0; divisor = '0;
    #2;
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_by_zero, 0);
    check("rst_ov", overflow, 0);
    idle_cycle();
    rst = 1'b0;

    // Round trip of 0xFF * 0x7F
    start_op(8'h7E, 8'h81, 8'hFF);
    wait_done(9, 8);
    idle_cycle();

    start_op(8'h00, 8'hC8, 8'h07);
    wait_done(9, 8);
    idle_cycle();

    start_op(8'h12, 8'h34, 8'h00);
    wait_done(1, 0);
    idle_cycle();
    start_op(8'h12, 8'h34, 8'h10);
    wait_done(1, 0);
    idle_cycle();

    // A second start while running must be ignored
    start_op(8'h00, 8'h05, 8'h0A);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; dividend2 = 8'h03; dividend1 = 8'h99; divisor = 8'h21;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(0, -1);
    repeat (12) @(negedge clk);
    check("ignored_start_done_count", done_count, ops_expected);

    // Back-to-back: second request raised during the done cycle
    idle_cycle();
    start_op(8'h7E, 8'h81, 8'hFF);
    wait_done(9, 8);
    start_op(8'h00, 8'hFF, 8'h01);
    wait_done(9, 8);
    idle_cycle();
    idle_cycle();
    check("b2b_done_count", done_count, ops_expected);

    // Asynchronous reset in the middle of a run
    start_op(8'h00, 8'hC8, 8'h07);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dz", div_by_zero, 0);
    check("abort_ov", overflow, 0);
    check("abort_pending", sb.size(), 1);
    sb.delete();
    ops_expected--;
    idle_cycle();
    idle_cycle();
    rst = 1'b0;
    start_op(8'h00, 8'hC8, 8'h07);
    wait_done(9, 8);
    idle_cycle();

    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] dv, d2, d1;
      dv = W'($urandom_range(1, 255));
      d2 = W'($urandom_range(0, int'(dv) - 1));
      d1 = W'($urandom);
      start_op(d2, d1, dv);
      wait_done(9, 8);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    idle_cycle();
    idle_cycle();
    check("final_done_count", done_count, ops_expected);
    check("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
